// File: rtl/link_train_ctrl_if.sv
// Bus between the partition top-level and link_train_ctrl: requests and payload in,
// serializer word, aligner reset and link status out.
interface link_train_ctrl_if #(
  parameter int SERIALIZATION = 8,
  parameter int CHANNELS      = 4,
  parameter int MAX_RETRIES   = 3
);
  localparam int DW = SERIALIZATION * CHANNELS;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          i_start;
  logic          i_retrain;
  logic          i_slip_ready;
  logic [DW-1:0] i_tx_data;
  logic [DW-1:0] o_tx_data;
  logic          o_slip_rst;
  logic          o_tx_train;
  logic          o_link_up;
  logic          o_fail;
  logic [RW-1:0] o_retry_cnt;
  logic [2:0]    o_state;

  modport master (
    output i_start, i_retrain, i_slip_ready, i_tx_data,
    input  o_tx_data, o_slip_rst, o_tx_train, o_link_up, o_fail, o_retry_cnt, o_state
  );

  modport slave (
    input  i_start, i_retrain, i_slip_ready, i_tx_data,
    output o_tx_data, o_slip_rst, o_tx_train, o_link_up, o_fail, o_retry_cnt, o_state
  );
endinterface

// File: rtl/link_train_ctrl.sv
// Link-training sequencer: aligner reset, sync-pattern training, drain, link up, bounded retries.
// Optional: LINK_TRAIN_AUTO_RESTART_EN makes FAIL restart training after BACKOFF_CYCLES.
module link_train_ctrl #(
  parameter int          SERIALIZATION  = 8,
  parameter int          CHANNELS       = 4,
  parameter logic [7:0]  SYNC_PATTERN   = 8'hF0,
  parameter int          RST_CYCLES     = 4,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          DRAIN_CYCLES   = 64,
  parameter int          MAX_RETRIES    = 3,
  parameter int          BACKOFF_CYCLES = 1024
) (
  input logic              i_clk,
  input logic              i_rst,
  link_train_ctrl_if.slave bus
);
  localparam int RW   = $clog2(MAX_RETRIES + 1);
  localparam int CM0  = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CM1  = (DRAIN_CYCLES > BACKOFF_CYCLES) ? DRAIN_CYCLES : BACKOFF_CYCLES;
  localparam int CMAX = (CM0 > CM1) ? CM0 : CM1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [SERIALIZATION-1:0] SYNC_W = SERIALIZATION'(SYNC_PATTERN);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_SLIP = 3'd1,
    S_TRAIN      = 3'd2,
    S_DRAIN      = 3'd3,
    S_LINK_UP    = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry, w_retry_next;
  logic          w_attempt_fail;
  logic          w_train;
  logic [CHANNELS-1:0][SERIALIZATION-1:0] w_lane;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      // cleared on every entry, saturating elsewhere so idle dwell can never wrap
      if (w_next != r_state)     r_cnt <= '0;
      else if (r_cnt != CW'(CMAX)) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_retry_next   = r_retry;
    w_attempt_fail = 1'b0;
    if (!bus.i_start) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next       = S_RESET_SLIP;
          w_retry_next = '0;
        end
        S_RESET_SLIP: if (r_cnt == CW'(RST_CYCLES - 1)) w_next = S_TRAIN;
        S_TRAIN: begin
          if (bus.i_slip_ready)                        w_next = S_DRAIN;
          else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) w_attempt_fail = 1'b1;
        end
        S_DRAIN: begin
          if (!bus.i_slip_ready)                     w_attempt_fail = 1'b1;
          else if (r_cnt == CW'(DRAIN_CYCLES - 1))   w_next = S_LINK_UP;
        end
        S_LINK_UP: begin
          if (bus.i_retrain) begin
            w_next       = S_RESET_SLIP;
            w_retry_next = '0;
          end
        end
        S_FAIL: begin
`ifdef LINK_TRAIN_AUTO_RESTART_EN
          if (r_cnt == CW'(BACKOFF_CYCLES - 1)) begin
            w_next       = S_RESET_SLIP;
            w_retry_next = '0;
          end
`endif
        end
        default: w_next = S_IDLE;
      endcase
      if (w_attempt_fail) begin
        if (r_retry == RW'(MAX_RETRIES)) begin
          w_next = S_FAIL;
        end else begin
          w_next       = S_RESET_SLIP;
          w_retry_next = r_retry + 1'b1;
        end
      end
    end
  end

  assign w_train = (r_state == S_RESET_SLIP) || (r_state == S_TRAIN) || (r_state == S_DRAIN);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign w_lane[g] = w_train                ? SYNC_W :
                       (r_state == S_LINK_UP) ? bus.i_tx_data[g*SERIALIZATION +: SERIALIZATION] :
                                                '0;
  end

  // status outputs are a registered decode of the state, so they trail it by one cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_state     <= 3'd0;
      bus.o_slip_rst  <= 1'b1;
      bus.o_tx_train  <= 1'b0;
      bus.o_link_up   <= 1'b0;
      bus.o_fail      <= 1'b0;
      bus.o_retry_cnt <= '0;
      bus.o_tx_data   <= '0;
    end else begin
      bus.o_state     <= r_state;
      bus.o_slip_rst  <= (r_state == S_IDLE) || (r_state == S_RESET_SLIP) || (r_state == S_FAIL);
      bus.o_tx_train  <= w_train;
      bus.o_link_up   <= (r_state == S_LINK_UP);
      bus.o_fail      <= (r_state == S_FAIL);
      bus.o_retry_cnt <= r_retry;
      bus.o_tx_data   <= w_lane;
    end
  end
endmodule

// File: tb/tb_link_train_ctrl.sv
// Scoreboarded bench for link_train_ctrl: expectations are queued with a due cycle when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_link_train_ctrl;
  localparam int RST = 4, TO = 256, DR = 64, MR = 3, BO = 1024;
  localparam int PER = RST + TO;
  localparam logic [31:0] PAT = 32'hF0F0F0F0;
  localparam logic [31:0] PAY = 32'h12345678;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  link_train_ctrl_if bus();
  link_train_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] want;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       return 32'(bus.o_state);
      1:       return 32'(bus.o_slip_rst);
      2:       return 32'(bus.o_tx_train);
      3:       return 32'(bus.o_link_up);
      4:       return 32'(bus.o_fail);
      5:       return 32'(bus.o_retry_cnt);
      default: return bus.o_tx_data;
    endcase
  endfunction

  task automatic ex(input int due, input int sel, input logic [31:0] want, input string tag);
    exp_t e;
    e.due = due; e.sel = sel; e.want = want; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs(sb[i].sel), sb[i].want);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        chk({sb[i].tag, "_late"}, 32'(cyc), 32'(sb[i].due));
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic drain_sb(input int budget);
    int b = 0;
    while (sb.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    if (sb.size() != 0) begin
      chk("sb_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, obs(0), 32'd0);
    chk({tag, "_srst"},  obs(1), 32'd1);
    chk({tag, "_train"}, obs(2), 32'd0);
    chk({tag, "_lu"},    obs(3), 32'd0);
    chk({tag, "_fail"},  obs(4), 32'd0);
    chk({tag, "_retry"}, obs(5), 32'd0);
    chk({tag, "_data"},  obs(6), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, n, r, p, d, f, fe;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_retrain = 1'b0;
    bus.i_slip_ready = 1'b0;
    bus.i_tx_data = PAY;
    #12;
    chk_reset_vals("rst");
    rst = 1'b0;
    tick(2);

    // lock on first attempt
    e0 = cyc + 1;
    bus.i_start = 1'b1;
    ex(e0, 0, 0, "s1_lag");
    ex(e0 + 1, 0, 1, "s1_rs");
    ex(e0 + 1, 2, 1, "s1_train_hi");
    ex(e0 + 1, 6, PAT, "s1_pattern");
    ex(e0 + RST, 1, 1, "s1_srst_hold");
    ex(e0 + RST + 1, 1, 0, "s1_srst_rel");
    ex(e0 + RST + 1, 0, 2, "s1_train");
    n = e0 + RST + 20;
    wait_to(n - 1);
    bus.i_slip_ready = 1'b1;
    ex(n, 0, 2, "s1_still_train");
    ex(n + 1, 0, 3, "s1_drain");
    ex(n + DR, 3, 0, "s1_lu_early");
    ex(n + DR, 6, PAT, "s1_pattern_drain");
    ex(n + DR + 1, 3, 1, "s1_lu");
    ex(n + DR + 1, 0, 4, "s1_state_lu");
    ex(n + DR + 1, 5, 0, "s1_retry");
    ex(n + DR + 1, 2, 0, "s1_train_lo");
    ex(n + DR + 1, 6, PAY, "s1_payload");
    drain_sb(200);
    r = cyc + 1;
    bus.i_slip_ready = 1'b0;
    bus.i_tx_data = 32'hA5C3_0F96;
    ex(r + 3, 0, 4, "s1_ignore_ready");
    ex(r + 3, 6, 32'hA5C3_0F96, "s1_payload2");
    drain_sb(20);
    bus.i_slip_ready = 1'b1;
    tick();

    // retrain, then retrain together with start low
    r = cyc + 1;
    bus.i_retrain = 1'b1;
    tick();
    bus.i_retrain = 1'b0;
    ex(r + 1, 3, 0, "s2_lu_drop");
    ex(r + 1, 0, 1, "s2_rs");
    ex(r + 1, 1, 1, "s2_srst");
    ex(r + RST + 1 + DR + 1, 0, 4, "s2_relock");
    drain_sb(200);
    p = cyc + 1;
    bus.i_retrain = 1'b1;
    bus.i_start = 1'b0;
    tick();
    bus.i_retrain = 1'b0;
    ex(p + 1, 0, 0, "s2_prec_idle");
    ex(p + 1, 3, 0, "s2_prec_lu");
    ex(p + 1, 1, 1, "s2_prec_srst");
    ex(p + 2, 6, 0, "s2_idle_data");
    drain_sb(20);

    // ready lost during drain
    bus.i_slip_ready = 1'b0;
    tick(2);
    e0 = cyc + 1;
    bus.i_start = 1'b1;
    n = e0 + RST + 2;
    wait_to(n - 1);
    bus.i_slip_ready = 1'b1;
    d = n + 10;
    wait_to(d - 1);
    bus.i_slip_ready = 1'b0;
    ex(d, 0, 3, "s3_drain");
    ex(d + 1, 0, 1, "s3_rs");
    ex(d + 1, 5, 1, "s3_retry");
    ex(n + DR + 1, 3, 0, "s3_no_lu");
    ex(n + DR + 1, 0, 2, "s3_train2");
    drain_sb(200);
    bus.i_start = 1'b0;
    tick(2);

    // retry exhaustion
    e0 = cyc + 1;
    bus.i_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ex(e0 + PER * k + 5, 0, 2, $sformatf("s4_train_start%0d", k));
      ex(e0 + PER * (k + 1), 0, 2, $sformatf("s4_train_end%0d", k));
    end
    for (int k = 1; k <= MR; k++) begin
      ex(e0 + PER * k + 1, 0, 1, $sformatf("s4_rs%0d", k));
      ex(e0 + PER * k + 1, 5, k, $sformatf("s4_retry%0d", k));
    end
    fe = e0 + PER * (MR + 1);
    ex(fe + 1, 0, 5, "s4_fail_state");
    ex(fe + 1, 4, 1, "s4_fail");
    ex(fe + 1, 1, 1, "s4_fail_srst");
    ex(fe + 1, 2, 0, "s4_fail_train");
    ex(fe + 1, 5, MR, "s4_retry_sat");
`ifdef LINK_TRAIN_AUTO_RESTART_EN
    ex(fe + BO, 0, 5, "s4_backoff_hold");
    ex(fe + BO + 1, 0, 1, "s4_restart");
    ex(fe + BO + 1, 5, 0, "s4_restart_retry");
    ex(fe + BO + 1, 4, 0, "s4_restart_fail");
`else
    ex(fe + 5001, 0, 5, "s4_sticky");
    ex(fe + 5001, 4, 1, "s4_sticky_fail");
`endif
    drain_sb(7000);
    f = cyc + 1;
    bus.i_start = 1'b0;
    ex(f + 1, 0, 0, "s4_idle");
    ex(f + 1, 4, 0, "s4_idle_fail");
    drain_sb(20);

    // asynchronous reset in the middle of TRAIN
    e0 = cyc + 1;
    bus.i_start = 1'b1;
    wait_to(e0 + RST + 10);
    @(negedge clk);
    chk("s5_pre_train", obs(0), 32'd2);
    #1 rst = 1'b1;
    #1 chk_reset_vals("s5");
    #1 rst = 1'b0;
    ex(cyc + 1, 0, 0, "s5_idle_first");
    ex(cyc + 2, 0, 1, "s5_restart");
    drain_sb(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
